// File: rtl/fetch_pc_ifid.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and captures the returned instruction into the IF/ID pipeline register.
module fetch_pc_ifid #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] MEM_BYTES = 32'd400
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIR,
  input  logic [31:0] TGT,
  input  logic [31:0] INS,
  output logic [31:0] DR,
  output logic [31:0] INS_ID,
  output logic [31:0] PC4_ID,
  output logic        VALID_ID,
  output logic        MISAL,
  output logic        OOR_ERR,
  output logic [31:0] FCNT
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_REDIRECT,
    ACT_HOLD,
    ACT_FETCH,
    ACT_OUT_OF_RANGE
  } action_e;

  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] redir_pc;
  logic        in_range;
  logic        tgt_misaligned;
  action_e     action;

  assign DR             = pc;
  assign pc_seq         = pc + 32'd4;
  assign redir_pc       = {TGT[31:2], 2'b00};
  assign in_range       = (pc < MEM_BYTES);
  assign tgt_misaligned = (TGT[1:0] != 2'b00);

  // One decision per cycle, in priority order: reset, redirect, stall, fetch.
  always_comb begin
    // NOTE: default first so every path assigns action and no latch is inferred.
    action = ACT_FETCH;
    if (RST) begin
      action = ACT_RESET;
    end else if (REDIR) begin
      action = ACT_REDIRECT;
    end else if (STALL) begin
      action = ACT_HOLD;
    end else if (!in_range) begin
      action = ACT_OUT_OF_RANGE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates take
  // effect together at the clock edge, independent of statement order.
  always_ff @(posedge CLK) begin
    unique case (action)
      ACT_RESET: begin
        pc       <= RESET_PC;
        INS_ID   <= 32'd0;
        PC4_ID   <= 32'd0;
        VALID_ID <= 1'b0;
        MISAL    <= 1'b0;
        OOR_ERR  <= 1'b0;
        FCNT     <= 32'd0;
      end
      ACT_REDIRECT: begin
        // The instruction on INS this cycle is wrong-path; decode sees a NOP.
        pc       <= redir_pc;
        INS_ID   <= 32'd0;
        PC4_ID   <= 32'd0;
        VALID_ID <= 1'b0;
        MISAL    <= tgt_misaligned;
      end
      ACT_HOLD: begin
        MISAL <= 1'b0;
      end
      ACT_FETCH: begin
        pc       <= pc_seq;
        INS_ID   <= INS;
        PC4_ID   <= pc_seq;
        VALID_ID <= 1'b1;
        MISAL    <= 1'b0;
        FCNT     <= FCNT + 32'd1;
      end
      ACT_OUT_OF_RANGE: begin
        // Fetch proceeds past the end of memory; only the error flag records it.
        pc       <= pc_seq;
        INS_ID   <= 32'd0;
        PC4_ID   <= pc_seq;
        VALID_ID <= 1'b0;
        MISAL    <= 1'b0;
        OOR_ERR  <= 1'b1;
      end
      default: begin
        MISAL <= 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Scoreboard bench for fetch_pc_ifid: three instances (default, tiny memory,
// wrap-around reset PC) share one stimulus stream; a monitor checks each cycle.
module tb_fetch_pc_ifid;

  localparam logic [31:0] B_MEM    = 32'd16;
  localparam logic [31:0] C_RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] C_MEM    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        valid;
    logic        misal;
    logic        oor;
    logic [31:0] fcnt;
  } st_t;

  typedef struct packed {
    st_t a;
    st_t b;
    st_t c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, redir;
  logic [31:0] tgt;

  logic [31:0] dr_a, ins_a, insid_a, pc4_a, fcnt_a;
  logic        val_a, mis_a, oor_a;
  logic [31:0] dr_b, ins_b, insid_b, pc4_b, fcnt_b;
  logic        val_b, mis_b, oor_b;
  logic [31:0] dr_c, ins_c, insid_c, pc4_c, fcnt_c;
  logic        val_c, mis_c, oor_c;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];
  st_t  ma, mb, mc;
  bit   model_known = 0;

  always #5 clk = ~clk;

  // Instruction memory model: each word returns 0xA0000000 + its address.
  assign ins_a = 32'hA000_0000 + dr_a;
  assign ins_b = 32'hA000_0000 + dr_b;
  assign ins_c = 32'hA000_0000 + dr_c;

  fetch_pc_ifid u_a (
    .CLK(clk), .RST(rst), .STALL(stall), .REDIR(redir), .TGT(tgt), .INS(ins_a),
    .DR(dr_a), .INS_ID(insid_a), .PC4_ID(pc4_a), .VALID_ID(val_a),
    .MISAL(mis_a), .OOR_ERR(oor_a), .FCNT(fcnt_a)
  );

  fetch_pc_ifid #(.MEM_BYTES(B_MEM)) u_b (
    .CLK(clk), .RST(rst), .STALL(stall), .REDIR(redir), .TGT(tgt), .INS(ins_b),
    .DR(dr_b), .INS_ID(insid_b), .PC4_ID(pc4_b), .VALID_ID(val_b),
    .MISAL(mis_b), .OOR_ERR(oor_b), .FCNT(fcnt_b)
  );

  fetch_pc_ifid #(.RESET_PC(C_RST_PC), .MEM_BYTES(C_MEM)) u_c (
    .CLK(clk), .RST(rst), .STALL(stall), .REDIR(redir), .TGT(tgt), .INS(ins_c),
    .DR(dr_c), .INS_ID(insid_c), .PC4_ID(pc4_c), .VALID_ID(val_c),
    .MISAL(mis_c), .OOR_ERR(oor_c), .FCNT(fcnt_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour of one clock edge, from the fetch-stage rules.
  function automatic st_t step(input st_t s, input logic r, input logic st, input logic rd,
                               input logic [31:0] t, input logic [31:0] reset_pc,
                               input logic [31:0] mem_bytes);
    st_t n;
    logic [31:0] fetched;
    if (r) begin
      n = '0;
      n.pc = reset_pc;
      return n;
    end
    n = s;
    n.misal = rd && (t % 4 != 0);
    if (rd) begin
      n.pc    = t - (t % 4);
      n.ins   = 0;
      n.pc4   = 0;
      n.valid = 0;
    end else if (!st) begin
      fetched = 32'hA000_0000 + s.pc;
      n.pc  = s.pc + 4;
      n.pc4 = s.pc + 4;
      if (s.pc < mem_bytes) begin
        n.ins   = fetched;
        n.valid = 1;
        n.fcnt  = s.fcnt + 1;
      end else begin
        n.ins   = 0;
        n.valid = 0;
        n.oor   = 1;
      end
    end
    return n;
  endfunction

  // Apply one cycle of stimulus; the predicted post-edge state goes to the scoreboard.
  task automatic cycle(input logic r, input logic st, input logic rd, input logic [31:0] t);
    rst = r; stall = st; redir = rd; tgt = t;
    if (model_known || r) begin
      ma = step(ma, r, st, rd, t, 32'd0, 32'd400);
      mb = step(mb, r, st, rd, t, 32'd0, B_MEM);
      mc = step(mc, r, st, rd, t, C_RST_PC, C_MEM);
      model_known = 1;
      exp_q.push_back('{a: ma, b: mb, c: mc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_inst(input string tag, input st_t e,
                          input logic [31:0] dr, input logic [31:0] ins_id,
                          input logic [31:0] pc4, input logic v, input logic m,
                          input logic o, input logic [31:0] fc);
    check({tag, ".DR"},       dr,     e.pc);
    check({tag, ".INS_ID"},   ins_id, e.ins);
    check({tag, ".PC4_ID"},   pc4,    e.pc4);
    check({tag, ".VALID_ID"}, {31'd0, v}, {31'd0, e.valid});
    check({tag, ".MISAL"},    {31'd0, m}, {31'd0, e.misal});
    check({tag, ".OOR_ERR"},  {31'd0, o}, {31'd0, e.oor});
    check({tag, ".FCNT"},     fc,     e.fcnt);
  endtask

  // Monitor: each predicted edge is compared half a cycle after it happens.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_inst("a", e.a, dr_a, insid_a, pc4_a, val_a, mis_a, oor_a, fcnt_a);
      cmp_inst("b", e.b, dr_b, insid_b, pc4_b, val_b, mis_b, oor_b, fcnt_b);
      cmp_inst("c", e.c, dr_c, insid_c, pc4_c, val_c, mis_c, oor_c, fcnt_c);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'd0;

    // Reset, then sequential fetch from 0.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst.DR", dr_a, 32'd0);
    check("rst.c.DR", dr_c, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("seq.DR", dr_a, 32'd8);
    check("seq.INS_ID", insid_a, 32'hA000_0004);
    check("c.wrap.DR", dr_c, 32'd0);

    // Stall at DR=8 for three cycles, then release.
    repeat (3) cycle(0, 1, 0, 0);
    check("stall.DR", dr_a, 32'd8);
    check("stall.INS_ID", insid_a, 32'hA000_0004);
    check("stall.FCNT", fcnt_a, 32'd2);
    cycle(0, 0, 0, 0);
    check("release.DR", dr_a, 32'd12);
    check("release.INS_ID", insid_a, 32'hA000_0008);
    check("release.FCNT", fcnt_a, 32'd3);

    // Redirect with stall asserted: redirect wins and flushes.
    cycle(0, 1, 1, 32'd100);
    check("redir.DR", dr_a, 32'd100);
    check("redir.VALID_ID", {31'd0, val_a}, 32'd0);
    check("redir.FCNT", fcnt_a, 32'd3);
    cycle(0, 0, 0, 0);
    check("after_redir.INS_ID", insid_a, 32'hA000_0064);
    check("after_redir.PC4_ID", pc4_a, 32'd104);

    // Misaligned target: truncated, one-cycle MISAL pulse.
    cycle(0, 0, 1, 32'd22);
    check("misal.DR", dr_a, 32'd20);
    check("misal.pulse", {31'd0, mis_a}, 32'd1);
    cycle(0, 0, 0, 0);
    check("misal.clear", {31'd0, mis_a}, 32'd0);

    // Out of range on the small-memory instance.
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    check("oor.VALID_ID", {31'd0, val_b}, 32'd0);
    check("oor.INS_ID", insid_b, 32'd0);
    check("oor.flag", {31'd0, oor_b}, 32'd1);
    check("oor.FCNT", fcnt_b, 32'd4);
    repeat (2) cycle(0, 0, 0, 0);
    check("oor.sticky", {31'd0, oor_b}, 32'd1);

    // Reset during a redirect cycle.
    cycle(1, 1, 1, 32'd40);
    check("rst_redir.DR", dr_c, 32'hFFFF_FFF8);
    check("rst_redir.VALID_ID", {31'd0, val_c}, 32'd0);
    check("rst_redir.OOR_ERR", {31'd0, oor_b}, 32'd0);
    check("rst_redir.FCNT", fcnt_b, 32'd0);
    cycle(0, 0, 0, 0);
    check("c.seq.DR", dr_c, 32'hFFFF_FFFC);

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 511));
      cycle(r, s, d, t);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(negedge clk);
      drain++;
    end
    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
